// File: rtl/setpoint_stepper_if.sv
// ============================================================================
//  setpoint_stepper_if
//  Command/pulse bundle between a level-commanding controller and the stepper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface setpoint_stepper_if #(
  parameter int unsigned N = 8
);
  logic         tick;
  logic [N-1:0] target;
  logic         load;
  logic         abort;
  logic         inc;
  logic         dec;
  logic [N-1:0] mirror;
  logic         busy;
  logic         done;

  modport master (
    output tick, target, load, abort,
    input  inc, dec, mirror, busy, done
  );

  modport slave (
    input  tick, target, load, abort,
    output inc, dec, mirror, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/setpoint_stepper.sv
// ============================================================================
//  setpoint_stepper
//  Steps a shadow counter toward a commanded target, one inc/dec pulse per
//  STEP_TICKS ticks. Optional idle decay: SETPOINT_STEPPER_DECAY_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module setpoint_stepper #(
  parameter int unsigned N           = 8,
  parameter int unsigned DEFAULT_VAL = 2,
  parameter int unsigned STEP_TICKS  = 4,
  parameter int unsigned DECAY_TICKS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  setpoint_stepper_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned   TW        = $clog2(STEP_TICKS + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
  localparam logic [N-1:0]  RST_VAL   = N'(DEFAULT_VAL);
  localparam logic [N-1:0]  ONE       = N'(1);

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [N-1:0]  mirror_q, mirror_d;
  logic [N-1:0]  target_q, target_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

`ifdef SETPOINT_STEPPER_DECAY_EN
  localparam int unsigned   DW        = $clog2(DECAY_TICKS + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECAY_TICKS - 1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

  logic [DW-1:0] dcnt_q, dcnt_d;
`endif

  // Zero tick counts are meaningless; keep both parameters referenced in every build.
  if (STEP_TICKS < 1 || DECAY_TICKS < 1) begin : g_bad_params
  end

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    mirror_d = mirror_q;
    target_d = target_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
`ifdef SETPOINT_STEPPER_DECAY_EN
    dcnt_d   = '0;
`endif

    if (bus.abort) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
    end else if (bus.load) begin
      // A retarget keeps the interval phase; only a fresh command restarts it.
      target_d = bus.target;
      if (state_q == S_IDLE) tcnt_d = '0;
      state_d = (bus.target == mirror_q) ? S_DONE : S_WAIT;
    end else begin
      case (state_q)
        S_IDLE: begin
`ifdef SETPOINT_STEPPER_DECAY_EN
          if (mirror_q == '0) begin
            dcnt_d = '0;
          end else if (bus.tick) begin
            if (dcnt_q == DCNT_LAST) begin
              dec_d    = 1'b1;
              mirror_d = mirror_q - ONE;
              target_d = (target_q != '0) ? target_q - ONE : target_q;
            end else begin
              dcnt_d = dcnt_q + DCNT_ONE;
            end
          end else begin
            dcnt_d = dcnt_q;
          end
`endif
        end
        S_WAIT: begin
          if (bus.tick) begin
            if (tcnt_q == TCNT_LAST) begin
              tcnt_d  = '0;
              state_d = S_STEP;
              if (mirror_q < target_q) begin
                inc_d    = 1'b1;
                mirror_d = mirror_q + ONE;
              end else if (mirror_q > target_q) begin
                dec_d    = 1'b1;
                mirror_d = mirror_q - ONE;
              end
            end else begin
              tcnt_d = tcnt_q + TCNT_ONE;
            end
          end
        end
        S_STEP:  state_d = (mirror_q == target_q) ? S_DONE : S_WAIT;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_STEP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      mirror_q <= RST_VAL;
      target_q <= RST_VAL;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SETPOINT_STEPPER_DECAY_EN
      dcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      mirror_q <= mirror_d;
      target_q <= target_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SETPOINT_STEPPER_DECAY_EN
      dcnt_q   <= dcnt_d;
`endif
    end
  end

  assign bus.inc    = inc_q;
  assign bus.dec    = dec_q;
  assign bus.mirror = mirror_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

`default_nettype wire
